beacon_sched: RTL and testbench
===============================

Name: beacon_sched

Overview:
- Parametrised transponder scheduler for the phase_dsp beacon path.
- Collects a burst of RF receive strobes from the digitizer/hex_dump chain and counts them.
- Fires a transmit strobe and a TX enable window at BASE_DELAY plus half the burst length after the first strobe, so the reply is centred on the burst midpoint.
- Adds things the current beacon lacks: minimum-burst qualification, a configurable TX window, post-TX holdoff, an enable/abort control and status outputs.

Parameters:
- CNT_W, 8, width of the burst strobe counter; the counter saturates at 2^CNT_W-1.
- DLY_W, 9, width of the timer. Rule: BASE_DELAY + (2^CNT_W-1)/2 < 2^DLY_W.
- BASE_DELAY, 255, fixed delay term in clocks.
- MIN_CNT, 2, minimum strobes for a valid burst. Range 1..2^CNT_W-1.
- TX_LEN, 16, number of clocks tx_en stays high. Must be ≥ 1.
- HOLD, 64, number of clocks after TX during which rx_stb is ignored. 0 is allowed.

Ports:
- clk  in  1  system clock (48 MHz).
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  block enable; low forces IDLE.
- rx_stb  in  1  single-cycle RF receive strobe.
- tx_stb  out  1  single-cycle transmit trigger.
- tx_en  out  1  transmit window.
- busy  out  1  high in any state other than IDLE.
- dropped  out  1  single-cycle pulse when a burst is discarded.
- burst_cnt  out  CNT_W  strobe count of the last fired burst.

Behaviour:
- All outputs are registered. Reset value of every output is 0; the FSM resets to IDLE, and the counters and timer reset to 0.
- States and transitions:
  - IDLE: at an edge with enable=1 and rx_stb=1, go to COLLECT; count←1, timer←0.
  - COLLECT:
    - Timer increments every edge and saturates at 2^DLY_W-1.
    - rx_stb=1 increments count, saturating.
    - target = BASE_DELAY + (count>>1), recomputed from the current count each cycle.
    - At an edge where the pre-edge timer ≥ target and rx_stb=0:
      - if count ≥ MIN_CNT: go to TX; tx_stb=1 for one cycle, tx_en=1, burst_cnt←count.
      - else: go to IDLE, dropped=1 for one cycle.
    - A strobe coincident with the fire condition has priority: it is counted and firing is deferred.
  - TX: tx_en high for exactly TX_LEN cycles, then go to HOLDOFF (or to IDLE if HOLD=0). rx_stb is ignored.
  - HOLDOFF: HOLD cycles with rx_stb ignored, then IDLE. A strobe on the IDLE-return edge is not accepted; it must arrive in IDLE.
- Latency:
  - First strobe sampled at edge E0 → tx_stb rises at edge E0+target+1.
  - tx_en rises on the same edge as tx_stb.
  - busy rises at E0+1's cycle, i.e. it is registered at E0.
- enable=0 in any non-IDLE state: at the next edge go to IDLE, clearing tx_en, tx_stb and count. No dropped pulse; burst_cnt is retained.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0.
- Count saturation: further strobes are absorbed and target stops growing.
- With the parameter rule met, the timer cannot saturate before the target.

Test Plan:
- Reset and idle: rst pulse, then 20 idle cycles → all outputs 0, busy=0.
- Nominal fire: 10 strobes on consecutive edges E0..E0+9 → tx_stb one cycle at E0+261 (target 260), tx_en high 16 cycles, burst_cnt=10, then busy held a further 64 cycles, then low.
- Sub-minimum burst: a single strobe at E0 → dropped pulse at E0+256, no tx_stb, busy low after it.
- Coincident strobe:
  - 4 strobes at E0..E0+3, plus one strobe at E0+258, the edge where firing would occur (target 257).
  - → that strobe is counted (count=5, target still 257) and tx_stb moves to E0+259; burst_cnt=5.
- Holdoff and saturation:
  - Strobes during TX/HOLDOFF → ignored; the next burst starts only after busy falls.
  - 300 consecutive strobes → count saturates at 255, target 382, tx_stb at the first strobe-free edge with timer ≥ 382.
- Abort: enable drops 5 cycles into TX → tx_en low at the next edge, busy low, burst_cnt unchanged, no dropped pulse.

Source files
------------

// File: rtl/beacon_sched.sv
// beacon_sched: counts an RF strobe burst and fires a TX strobe/window centred on the burst midpoint.
module beacon_sched #(
    parameter int CNT_W      = 8,
    parameter int DLY_W      = 9,
    parameter int BASE_DELAY = 255,
    parameter int MIN_CNT    = 2,
    parameter int TX_LEN     = 16,
    parameter int HOLD       = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             rx_stb,
    output logic             tx_stb,
    output logic             tx_en,
    output logic             busy,
    output logic             dropped,
    output logic [CNT_W-1:0] burst_cnt
);
    // one timer serves the collect delay, the TX window and the holdoff, so it must fit all three
    localparam int TW0 = DLY_W > $clog2(TX_LEN + 1) ? DLY_W : $clog2(TX_LEN + 1);
    localparam int TW  = TW0 > $clog2(HOLD + 1) ? TW0 : $clog2(HOLD + 1);
    localparam logic [TW-1:0]    TMAX = TW'(2 ** DLY_W - 1);
    localparam logic [TW-1:0]    TXL  = TW'(TX_LEN - 1);
    localparam logic [TW-1:0]    HL   = TW'(HOLD == 0 ? 0 : HOLD - 1);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] MINC = CNT_W'(MIN_CNT);

    typedef enum logic [1:0] {IDLE, COLLECT, TX, HOLDOFF} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, burst_q, burst_d;
    logic [TW-1:0]    tmr_q, tmr_d, target;
    logic             tx_stb_q, tx_stb_d, tx_en_q, tx_en_d, busy_q, busy_d, drop_q, drop_d;

    assign target = TW'(BASE_DELAY) + TW'(cnt_q >> 1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        burst_d  = burst_q;
        tx_stb_d = 1'b0;
        tx_en_d  = tx_en_q;
        drop_d   = 1'b0;
        if (!enable && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            tmr_d   = '0;
            tx_en_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (enable && rx_stb) begin
                    state_d = COLLECT;
                    cnt_d   = CNT_W'(1);
                    tmr_d   = '0;
                end
                COLLECT: if (!rx_stb && tmr_q >= target) begin
                    tmr_d = '0;
                    if (cnt_q >= MINC) begin
                        state_d  = TX;
                        tx_stb_d = 1'b1;
                        tx_en_d  = 1'b1;
                        burst_d  = cnt_q;
                    end else begin
                        state_d = IDLE;
                        drop_d  = 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q == TMAX ? tmr_q : tmr_q + 1'b1;
                    cnt_d = rx_stb && cnt_q != CMAX ? cnt_q + 1'b1 : cnt_q;
                end
                TX: if (tmr_q == TXL) begin
                    state_d = HOLD == 0 ? IDLE : HOLDOFF;
                    tmr_d   = '0;
                    tx_en_d = 1'b0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
                HOLDOFF: if (tmr_q == HL) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tmr_q    <= '0;
            burst_q  <= '0;
            tx_stb_q <= 1'b0;
            tx_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            burst_q  <= burst_d;
            tx_stb_q <= tx_stb_d;
            tx_en_q  <= tx_en_d;
            busy_q   <= busy_d;
            drop_q   <= drop_d;
        end
    end

    assign tx_stb    = tx_stb_q;
    assign tx_en     = tx_en_q;
    assign busy      = busy_q;
    assign dropped   = drop_q;
    assign burst_cnt = burst_q;
endmodule

// File: tb/tb_beacon_sched.sv
// tb_beacon_sched: table-driven and randomized checks of beacon_sched against a strobe-timeline model.
module tb_beacon_sched;
    localparam int BASE = 255;
    localparam int MINC = 2;
    localparam int TXL  = 16;
    localparam int HLD  = 64;

    logic       clk = 1'b0;
    logic       rst, enable, rx_stb;
    logic       tx_stb, tx_en, busy, dropped;
    logic [7:0] burst_cnt;

    beacon_sched dut (
        .clk(clk), .rst(rst), .enable(enable), .rx_stb(rx_stb),
        .tx_stb(tx_stb), .tx_en(tx_en), .busy(busy), .dropped(dropped), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int extra;
        int abort;
        int fire;
        int cnt;
        bit drop;
    } vec_t;

    vec_t       tbl[9];
    bit         plan[0:1023];
    logic [7:0] prev;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_plan(input int n, input int extra);
        for (int i = 0; i < 1024; i++) plan[i] = (i < n) || (i == extra);
    endtask

    // Fire edge k: first strobe-free edge whose pre-edge timer (k-1) reaches BASE + count/2,
    // where count is the saturated number of strobes seen before that edge.
    task automatic run_plan(input int a, output int fire, output bit drp);
        int c, k, win;
        bit valid, act;
        logic [11:0] e;
        c = 0;
        k = 1023;
        for (int j = 1; j < 1024; j++) begin
            c = c + int'(plan[j-1]) > 255 ? 255 : c + int'(plan[j-1]);
            if (!plan[j] && j - 1 >= BASE + (c >> 1)) begin
                k = j;
                break;
            end
        end
        valid = c >= MINC;
        win   = k + TXL + HLD + 3;
        fire  = -1;
        drp   = 1'b0;
        for (int j = 0; j < win; j++) begin
            @(negedge clk);
            rx_stb = plan[j];
            enable = !(a >= 0 && j >= a);
            @(posedge clk);
            #1;
            act = a < 0 || j < a;
            if (act && valid && j == k) prev = 8'(c);
            e = {act && valid && j == k, act && valid && j >= k && j < k + TXL,
                 act && (valid ? j < k + TXL + HLD : j < k), act && !valid && j == k, prev};
            check($sformatf("cycle%0d", j), {tx_stb, tx_en, busy, dropped, burst_cnt}, e);
            if ((tx_stb || dropped) && fire < 0) fire = j;
            drp |= dropped;
        end
        rx_stb = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        int  f, a;
        bit  d;
        tbl[0] = '{10, -1, -1, 261, 10, 0};
        tbl[1] = '{1, -1, -1, 256, 10, 1};
        tbl[2] = '{4, 258, -1, 259, 5, 0};
        tbl[3] = '{2, -1, -1, 257, 2, 0};
        tbl[4] = '{10, 270, -1, 261, 10, 0};
        tbl[5] = '{10, 341, -1, 261, 10, 0};
        tbl[6] = '{300, -1, -1, 383, 255, 0};
        tbl[7] = '{10, -1, 266, 261, 10, 0};
        tbl[8] = '{5, -1, 100, -1, 10, 0};

        rst = 1'b1;
        enable = 1'b0;
        rx_stb = 1'b0;
        prev = '0;
        #1;
        check("reset", {tx_stb, tx_en, busy, dropped, burst_cnt}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("idle", {tx_stb, tx_en, busy, dropped, burst_cnt}, 0);
        end

        for (int i = 0; i < 9; i++) begin
            set_plan(tbl[i].n, tbl[i].extra);
            run_plan(tbl[i].abort, f, d);
            check($sformatf("vec%0d_fire", i), f, tbl[i].fire);
            check($sformatf("vec%0d_burst_cnt", i), {24'b0, burst_cnt}, tbl[i].cnt);
            check($sformatf("vec%0d_dropped", i), {31'b0, d}, {31'b0, tbl[i].drop});
        end

        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_stb = 1'b1;
            @(posedge clk);
            #1;
            check("disabled_strobe", {31'b0, busy}, 0);
        end
        @(negedge clk);
        rx_stb = 1'b0;
        enable = 1'b1;
        @(posedge clk);
        #1;
        check("disabled_after", {31'b0, busy}, 0);

        for (int r = 0; r < 12; r++) begin
            int dens, len;
            dens = $urandom_range(0, 100);
            len  = $urandom_range(1, 300);
            for (int i = 0; i < 1024; i++) plan[i] = 1'b0;
            plan[0] = 1'b1;
            for (int i = 1; i <= len; i++) plan[i] = $urandom_range(0, 99) < dens;
            a = $urandom_range(0, 3) == 0 ? $urandom_range(1, 350) : -1;
            run_plan(a, f, d);
        end

        set_plan(3, -1);
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            rx_stb = plan[j];
            @(posedge clk);
        end
        #1;
        check("mid_busy", {31'b0, busy}, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_reset", {tx_stb, tx_en, busy, dropped, burst_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;
        rx_stb = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset", {tx_stb, tx_en, busy, dropped, burst_cnt}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
